// File: rtl/gpll_ctrl_pkg.sv
// Shared types and constants for the GPLL reset / dynamic-phase-shift controller.
package gpll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_READY     = 3'd2,
    ST_STEP      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  localparam int unsigned SYNC_STAGES = 2;

  // Fastest step cadence: dps_en cycle, done through the synchroniser, edge detect.
  localparam int unsigned MIN_CYC_PER_STEP = 4;

  // Counter width able to hold max_val (at least one bit).
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpll_sync_bit.sv
// Multi-flop synchroniser for one asynchronous PLL status bit, with optional rising-edge strobe.
module gpll_sync_bit
  import gpll_ctrl_pkg::*;
#(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise_c
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic r_prev;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= o_sync;
        end
      end

      assign o_rise_c = o_sync & ~r_prev;
    end else begin : g_no_edge
      assign o_rise_c = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/gpll_dps_ctrl.sv
// GTP_GPLL sequencer: reset pulse, lock qualification, relock budget and
// handshaked dynamic-phase-shift stepping against DPS_DONE.
module gpll_dps_ctrl
  import gpll_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC   = 16,
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned DPS_TIMEOUT_CYC = 255,
  parameter int unsigned STEP_W          = 8,
  parameter int unsigned RELOCK_MAX      = 3,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pll_lock,
  input  logic              i_dps_done,
  input  logic              i_req_valid,
  input  logic [STEP_W-1:0] i_req_steps,
  output logic              o_req_ready,
  output logic              o_pll_rst,
  output logic              o_dps_en,
  output logic              o_dps_dir,
  output logic              o_locked,
  output logic              o_busy,
  output logic              o_seq_done,
  output logic              o_err_timeout,
  output logic              o_err_abort,
  output logic              o_fail,
  output logic [CNT_W-1:0]  o_lock_loss_cnt
);

  localparam int unsigned SEQ_MAX = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC
                                                                      : LOCK_STABLE_CYC;
  localparam int unsigned SEQ_W   = cnt_bits(SEQ_MAX);
  localparam int unsigned TO_W    = cnt_bits(DPS_TIMEOUT_CYC);
  localparam int unsigned MAG_W   = STEP_W + 1;

  localparam logic [SEQ_W-1:0] RST_LAST  = SEQ_W'(RST_PULSE_CYC - 1);
  localparam logic [SEQ_W-1:0] LOCK_LAST = SEQ_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(DPS_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_e             r_state;
  logic [SEQ_W-1:0]   r_seq_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [MAG_W-1:0]   r_remaining;
  logic               r_req_ready;
  logic               r_pll_rst;
  logic               r_dps_en;
  logic               r_dps_dir;
  logic               r_locked;
  logic               r_busy;
  logic               r_seq_done;
  logic               r_err_timeout;
  logic               r_err_abort;
  logic               r_fail;
  logic [CNT_W-1:0]   r_lock_loss_cnt;

  logic               w_lock;
  logic               w_lock_rise_unused;
  logic               w_done_rise;
  logic [MAG_W-1:0]   w_req_ext;
  logic [MAG_W-1:0]   w_req_mag;
  logic [CNT_W-1:0]   w_loss_next;
  logic               w_relock_spent;
  logic               w_lock_lost;

  gpll_sync_bit #(.EDGE_EN(1'b0)) u_sync_lock (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_async  (i_pll_lock),
    .o_sync   (w_lock),
    .o_rise_c (w_lock_rise_unused)
  );

  gpll_sync_bit #(.EDGE_EN(1'b1)) u_sync_done (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_async  (i_dps_done),
    .o_sync   (),
    .o_rise_c (w_done_rise)
  );

  // One extra bit so the most negative request has an exact magnitude.
  assign w_req_ext      = {i_req_steps[STEP_W-1], i_req_steps};
  assign w_req_mag      = w_req_ext[MAG_W-1] ? MAG_W'(~w_req_ext + MAG_W'(1)) : w_req_ext;
  assign w_loss_next    = (r_lock_loss_cnt == CNT_SAT) ? r_lock_loss_cnt
                                                       : CNT_W'(r_lock_loss_cnt + CNT_W'(1));
  assign w_relock_spent = (RELOCK_MAX != 0) && (32'(w_loss_next) >= RELOCK_MAX);
  assign w_lock_lost    = !w_lock && ((r_state == ST_READY) || (r_state == ST_STEP) ||
                                      (r_state == ST_WAIT_DONE));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_RST_PLL;
      r_seq_cnt       <= '0;
      r_to_cnt        <= '0;
      r_remaining     <= '0;
      r_req_ready     <= 1'b0;
      r_pll_rst       <= 1'b1;
      r_dps_en        <= 1'b0;
      r_dps_dir       <= 1'b0;
      r_locked        <= 1'b0;
      r_busy          <= 1'b0;
      r_seq_done      <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_err_abort     <= 1'b0;
      r_fail          <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_dps_en   <= 1'b0;
      r_seq_done <= 1'b0;

      // Lock loss outranks done and timeout in the same cycle.
      if (w_lock_lost) begin
        r_locked        <= 1'b0;
        r_req_ready     <= 1'b0;
        r_busy          <= 1'b0;
        r_remaining     <= '0;
        r_pll_rst       <= 1'b1;
        r_seq_cnt       <= '0;
        r_lock_loss_cnt <= w_loss_next;
        if (r_state != ST_READY) begin
          r_err_abort <= 1'b1;
          r_seq_done  <= 1'b1;
        end
        if (w_relock_spent) begin
          r_fail  <= 1'b1;
          r_state <= ST_FAIL;
        end else begin
          r_state <= ST_RST_PLL;
        end
      end else begin
        unique case (r_state)
          ST_RST_PLL: begin
            r_pll_rst <= 1'b1;
            if (r_seq_cnt == RST_LAST) begin
              r_seq_cnt <= '0;
              r_pll_rst <= 1'b0;
              r_state   <= ST_WAIT_LOCK;
            end else begin
              r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
            end
          end

          ST_WAIT_LOCK: begin
            if (!w_lock) begin
              r_seq_cnt <= '0;
            end else if (r_seq_cnt == LOCK_LAST) begin
              r_seq_cnt   <= '0;
              r_locked    <= 1'b1;
              r_req_ready <= 1'b1;
              r_state     <= ST_READY;
            end else begin
              r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
            end
          end

          ST_READY: begin
            if (i_req_valid) begin
              r_err_timeout <= 1'b0;
              r_err_abort   <= 1'b0;
              if (w_req_mag == '0) begin
                r_seq_done <= 1'b1;
              end else begin
                r_remaining <= w_req_mag;
                r_dps_dir   <= ~i_req_steps[STEP_W-1];
                r_dps_en    <= 1'b1;
                r_busy      <= 1'b1;
                r_req_ready <= 1'b0;
                r_state     <= ST_STEP;
              end
            end
          end

          ST_STEP: begin
            r_to_cnt <= '0;
            r_state  <= ST_WAIT_DONE;
          end

          ST_WAIT_DONE: begin
            if (w_done_rise) begin
              r_remaining <= r_remaining - MAG_W'(1);
              if (r_remaining == MAG_W'(1)) begin
                r_seq_done  <= 1'b1;
                r_busy      <= 1'b0;
                r_req_ready <= 1'b1;
                r_state     <= ST_READY;
              end else begin
                r_dps_en <= 1'b1;
                r_state  <= ST_STEP;
              end
            end else if (r_to_cnt == TO_LAST) begin
              r_err_timeout <= 1'b1;
              r_seq_done    <= 1'b1;
              r_remaining   <= '0;
              r_busy        <= 1'b0;
              r_req_ready   <= 1'b1;
              r_state       <= ST_READY;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end

          ST_FAIL: begin
            r_pll_rst <= 1'b1;
            r_fail    <= 1'b1;
          end

          default: begin
            r_state <= ST_RST_PLL;
          end
        endcase
      end
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_pll_rst       = r_pll_rst;
  assign o_dps_en        = r_dps_en;
  assign o_dps_dir       = r_dps_dir;
  assign o_locked        = r_locked;
  assign o_busy          = r_busy;
  assign o_seq_done      = r_seq_done;
  assign o_err_timeout   = r_err_timeout;
  assign o_err_abort     = r_err_abort;
  assign o_fail          = r_fail;
  assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_gpll_dps_ctrl.sv
// Bench for gpll_dps_ctrl: power-up/lock sequencing, a request table checked through a
// scoreboard, then abort, relock budget and FAIL recovery sequences.
`timescale 1ns/1ps
module tb_gpll_dps_ctrl;

  localparam int unsigned RST_PULSE_CYC   = 16;
  localparam int unsigned LOCK_STABLE_CYC = 32;
  localparam int unsigned DPS_TIMEOUT_CYC = 255;
  localparam int unsigned STEP_W          = 8;
  localparam int unsigned RELOCK_MAX      = 3;
  localparam int unsigned CNT_W           = 8;
  localparam int          SYNC_LAT        = 2;
  localparam int          DONE_DELAY      = 3;
  localparam int          NVEC            = 8;

  logic              clk;
  logic              i_rst;
  logic              i_pll_lock;
  logic              i_dps_done;
  logic              i_req_valid;
  logic [STEP_W-1:0] i_req_steps;
  logic              o_req_ready;
  logic              o_pll_rst;
  logic              o_dps_en;
  logic              o_dps_dir;
  logic              o_locked;
  logic              o_busy;
  logic              o_seq_done;
  logic              o_err_timeout;
  logic              o_err_abort;
  logic              o_fail;
  logic [CNT_W-1:0]  o_lock_loss_cnt;

  gpll_dps_ctrl #(
    .RST_PULSE_CYC   (RST_PULSE_CYC),
    .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
    .DPS_TIMEOUT_CYC (DPS_TIMEOUT_CYC),
    .STEP_W          (STEP_W),
    .RELOCK_MAX      (RELOCK_MAX),
    .CNT_W           (CNT_W)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_pll_lock      (i_pll_lock),
    .i_dps_done      (i_dps_done),
    .i_req_valid     (i_req_valid),
    .i_req_steps     (i_req_steps),
    .o_req_ready     (o_req_ready),
    .o_pll_rst       (o_pll_rst),
    .o_dps_en        (o_dps_en),
    .o_dps_dir       (o_dps_dir),
    .o_locked        (o_locked),
    .o_busy          (o_busy),
    .o_seq_done      (o_seq_done),
    .o_err_timeout   (o_err_timeout),
    .o_err_abort     (o_err_abort),
    .o_fail          (o_fail),
    .o_lock_loss_cnt (o_lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int steps;
    bit respond;
    int pulses;
    bit dir;
    bit to;
    bit ab;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[NVEC];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   last_en_cyc = 0;
  int   resp_cnt = 0;
  bit   resp_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: pulses and direction per request, verdict on seq_done.
  initial begin : monitor
    vec_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_dps_en) begin
        en_cnt++;
        last_en_cyc = cyc;
        check("dps_en_has_request", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          check("dps_dir_at_en", o_dps_dir, sb_q[0].dir);
          check("busy_at_en", o_busy, 1);
        end
      end
      if (o_seq_done) begin
        check("seq_done_has_request", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("pulse_count", en_cnt, e.pulses);
          check("dps_dir_at_done", o_dps_dir, e.dir);
          check("err_timeout_at_done", o_err_timeout, e.to);
          check("err_abort_at_done", o_err_abort, e.ab);
          // STEP cycle plus the full timeout wait.
          if (e.to) check("timeout_latency", cyc - last_en_cyc, DPS_TIMEOUT_CYC + 1);
        end
        en_cnt = 0;
      end
    end
  end

  // PLL DPS model: one-cycle DPS_DONE pulse DONE_DELAY cycles after each dps_en.
  initial begin : responder
    i_dps_done = 1'b0;
    forever begin
      @(negedge clk);
      i_dps_done = 1'b0;
      if (resp_cnt != 0) begin
        resp_cnt--;
        if (resp_cnt == 0) i_dps_done = 1'b1;
      end
      if (o_dps_en && resp_en) resp_cnt = DONE_DELAY;
    end
  end

  // Release reset at n=0; lock rises at lock_at, optional one-cycle glitch at glitch_at.
  task automatic power_up(input int lock_at, input int glitch_at,
                          output int first_rst_low, output int first_locked);
    first_rst_low = -1;
    first_locked  = -1;
    i_rst = 1'b0;
    for (int n = 0; n < 400 && first_locked < 0; n++) begin
      if (!o_pll_rst && first_rst_low < 0) first_rst_low = n;
      if (o_locked) first_locked = n;
      if (n == lock_at) i_pll_lock = 1'b1;
      if (glitch_at >= 0 && n == glitch_at) i_pll_lock = 1'b0;
      if (glitch_at >= 0 && n == glitch_at + 1) i_pll_lock = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic wait_locked(input string name);
    int w;
    w = 0;
    while (!o_locked && w < 500) begin
      @(negedge clk);
      w++;
    end
    check(name, o_locked, 1);
    check({name, "_ready"}, o_req_ready, 1);
  endtask

  task automatic issue(input vec_t v);
    int w;
    resp_en = v.respond;
    w = 0;
    while (!o_req_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_issue", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_steps = STEP_W'(v.steps);
    sb_q.push_back(v);
  endtask

  task automatic wait_drained(input string name);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Drop lock at a negedge; locked must hold for the sync delay, then fall.
  task automatic drop_lock(input int exp_cnt, input bit exp_fail);
    i_pll_lock = 1'b0;
    repeat (SYNC_LAT) @(negedge clk);
    check("locked_held_during_sync", o_locked, 1);
    @(negedge clk);
    check("locked_fell", o_locked, 0);
    check("pll_rst_after_loss", o_pll_rst, 1);
    check("lock_loss_cnt", o_lock_loss_cnt, exp_cnt);
    check("fail_after_loss", o_fail, exp_fail);
  endtask

  initial begin : stim
    int rst_low;
    int locked_at;
    int seen;
    int w;
    vec_t va;

    //           steps respond pulses dir to ab
    vecs[0] = '{    5,  1,   5, 1, 0, 0};
    vecs[1] = '{ -128,  1, 128, 0, 0, 0};
    vecs[2] = '{    0,  1,   0, 0, 0, 0};
    vecs[3] = '{    3,  0,   1, 1, 1, 0};
    vecs[4] = '{    0,  1,   0, 1, 0, 0};
    vecs[5] = '{   -1,  1,   1, 0, 0, 0};
    vecs[6] = '{  127,  0,   1, 1, 1, 0};
    vecs[7] = '{    2,  1,   2, 1, 0, 0};

    i_rst       = 1'b1;
    i_pll_lock  = 1'b0;
    i_req_valid = 1'b0;
    i_req_steps = '0;
    repeat (3) @(negedge clk);

    check("rst_pll_rst", o_pll_rst, 1);
    check("rst_dps_en", o_dps_en, 0);
    check("rst_dps_dir", o_dps_dir, 0);
    check("rst_locked", o_locked, 0);
    check("rst_busy", o_busy, 0);
    check("rst_req_ready", o_req_ready, 0);
    check("rst_seq_done", o_seq_done, 0);
    check("rst_err_timeout", o_err_timeout, 0);
    check("rst_err_abort", o_err_abort, 0);
    check("rst_fail", o_fail, 0);
    check("rst_lock_loss_cnt", o_lock_loss_cnt, 0);

    // Lock already stable when WAIT_LOCK starts: locked after RST + LOCK cycles.
    power_up(5, -1, rst_low, locked_at);
    check("pwr_pll_rst_width", rst_low, RST_PULSE_CYC);
    check("pwr_locked_at", locked_at, RST_PULSE_CYC + LOCK_STABLE_CYC);
    check("pwr_req_ready", o_req_ready, 1);

    // Glitch in WAIT_LOCK restarts qualification from the glitch's end.
    i_rst = 1'b1;
    i_pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    check("rerst_locked", o_locked, 0);
    power_up(5, 30, rst_low, locked_at);
    check("glitch_pll_rst_width", rst_low, RST_PULSE_CYC);
    check("glitch_locked_at", locked_at, 31 + SYNC_LAT + LOCK_STABLE_CYC);

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i]);
      @(negedge clk);
      i_req_valid = 1'b0;
      wait_drained("request_completed");
    end
    check("no_abort_after_table", o_err_abort, 0);
    check("table_lock_loss_cnt", o_lock_loss_cnt, 0);

    // Lose lock while step 2 of a +4 request is being pulsed.
    va = '{4, 1, 2, 1, 0, 1};
    issue(va);
    seen = 0;
    w = 0;
    while (seen < 2 && w < 200) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      if (o_dps_en) seen++;
      w++;
    end
    check("abort_second_pulse_seen", seen, 2);
    drop_lock(1, 1'b0);
    check("abort_err_abort", o_err_abort, 1);
    check("abort_busy", o_busy, 0);
    wait_drained("abort_seq_done");
    i_pll_lock = 1'b1;
    wait_locked("relock_after_abort");
    check("err_abort_sticky", o_err_abort, 1);

    // Second loss from READY: still within budget.
    drop_lock(2, 1'b0);
    i_pll_lock = 1'b1;
    wait_locked("relock_after_loss2");

    // Third loss exhausts the budget.
    drop_lock(3, 1'b1);
    i_pll_lock = 1'b1;
    i_req_valid = 1'b1;
    i_req_steps = STEP_W'(1);
    repeat (100) @(negedge clk);
    i_req_valid = 1'b0;
    check("fail_sticky", o_fail, 1);
    check("fail_pll_rst_held", o_pll_rst, 1);
    check("fail_locked", o_locked, 0);
    check("fail_req_ready", o_req_ready, 0);
    check("fail_busy", o_busy, 0);

    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_clears_fail", o_fail, 0);
    check("rst_clears_loss_cnt", o_lock_loss_cnt, 0);
    check("rst_pll_rst_again", o_pll_rst, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
